// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared constants, types and slot helper for the I2S master blocks
package i2s_pkg;

  localparam int unsigned SCLK_DIV   = 4;
  localparam int unsigned SLOT_BITS  = 32;
  localparam int unsigned FRAME_BITS = 64;
  localparam int unsigned LR_DIV     = 256;

  localparam int unsigned CNT_W    = $clog2(LR_DIV);
  localparam int unsigned SCLK_BIT = $clog2(SCLK_DIV) - 1;
  localparam int unsigned LR_BIT   = $clog2(LR_DIV) - 1;

  typedef logic [SLOT_BITS-1:0]  slot_t;
  typedef logic [FRAME_BITS-1:0] frame_t;

  typedef struct packed {
    slot_t l;
    slot_t r;
    logic  full;
  } hold_t;

  // Moves a right-aligned sample of 'bits' width to the top of its slot, zero below.
  function automatic slot_t pad_slot(input slot_t sample, input int unsigned bits);
    return sample << (SLOT_BITS - bits);
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// rtl/i2s_clkgen.sv - MCLK divider producing SCLK, LRCLK and frame/bit strobes
// Strobes are high during the last MCLK of a frame / bit period, so the next edge acts on them.
module i2s_clkgen
  import i2s_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  output logic sclk_o,
  output logic lrclk_o,
  output logic frame_tick_o,
  output logic bit_tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic             lrclk_q, lrclk_d;
  logic             frame_tick_q, frame_tick_d;
  logic             bit_tick_q, bit_tick_d;

  always_comb begin
    cnt_d        = cnt_q + CNT_W'(1);
    sclk_d       = cnt_d[SCLK_BIT];
    lrclk_d      = cnt_d[LR_BIT];
    frame_tick_d = (cnt_d == '1);
    bit_tick_d   = (cnt_d[SCLK_BIT:0] == '1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      sclk_q       <= 1'b0;
      lrclk_q      <= 1'b0;
      frame_tick_q <= 1'b0;
      bit_tick_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      sclk_q       <= sclk_d;
      lrclk_q      <= lrclk_d;
      frame_tick_q <= frame_tick_d;
      bit_tick_q   <= bit_tick_d;
    end
  end

  assign sclk_o       = sclk_q;
  assign lrclk_o      = lrclk_q;
  assign frame_tick_o = frame_tick_q;
  assign bit_tick_o   = bit_tick_q;

endmodule

// File: rtl/i2s_p2s.sv
// rtl/i2s_p2s.sv - I2S master transmitter: one-deep sample holding register, Philips framing
// The frame register shifts left each bit; its MSB after 63 shifts is the old LSB, giving the one-bit delay.
module i2s_p2s
  import i2s_pkg::*;
#(
  parameter int unsigned BIT_NUM = 16
) (
  input  logic               mclk_i,
  input  logic               rst_i,
  input  logic [BIT_NUM-1:0] data_l_i,
  input  logic [BIT_NUM-1:0] data_r_i,
  input  logic               data_valid_i,
  output logic               data_ready_o,
  input  logic               mute_i,
  output logic               sclk_o,
  output logic               lrclk_o,
  output logic               sdata_o,
  output logic               underrun_o
);

  logic   frame_tick;
  logic   bit_tick;
  logic   accept;

  hold_t  hold_q, hold_d;
  frame_t frame_q, frame_d;
  logic   sdata_q, sdata_d;
  logic   ready_q, ready_d;
  logic   underrun_q, underrun_d;

  i2s_clkgen u_clkgen (
    .clk_i        (mclk_i),
    .rst_i        (rst_i),
    .sclk_o       (sclk_o),
    .lrclk_o      (lrclk_o),
    .frame_tick_o (frame_tick),
    .bit_tick_o   (bit_tick)
  );

  assign accept = data_valid_i && ready_q;

  always_comb begin
    hold_d     = hold_q;
    frame_d    = frame_q;
    sdata_d    = sdata_q;
    underrun_d = 1'b0;

    if (bit_tick) begin
      sdata_d = frame_q[FRAME_BITS-1];
      frame_d = {frame_q[FRAME_BITS-2:0], 1'b0};
    end

    // A held pair is consumed at the boundary even when the frame is muted.
    if (frame_tick) begin
      frame_d     = (mute_i || !hold_q.full) ? '0 : {hold_q.l, hold_q.r};
      hold_d.full = 1'b0;
      underrun_d  = !hold_q.full;
    end

    if (accept) begin
      hold_d.l    = pad_slot(slot_t'(data_l_i), BIT_NUM);
      hold_d.r    = pad_slot(slot_t'(data_r_i), BIT_NUM);
      hold_d.full = 1'b1;
    end

    ready_d = !hold_d.full;
  end

  always_ff @(posedge mclk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_q     <= '0;
      frame_q    <= '0;
      sdata_q    <= 1'b0;
      ready_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      frame_q    <= frame_d;
      sdata_q    <= sdata_d;
      ready_q    <= ready_d;
      underrun_q <= underrun_d;
    end
  end

  assign data_ready_o = ready_q;
  assign sdata_o      = sdata_q;
  assign underrun_o   = underrun_q;

endmodule

// File: tb/tb_i2s_p2s.sv
// tb/tb_i2s_p2s.sv - frame-level directed bench for i2s_p2s at 16, 24 and 32-bit sample widths
module tb_i2s_p2s;

  logic mclk = 1'b0;
  logic rst  = 1'b1;
  logic valid = 1'b0;
  logic mute  = 1'b0;

  logic [15:0] dl16 = '0, dr16 = '0;
  logic [23:0] dl24 = '0, dr24 = '0;
  logic [31:0] dl32 = '0, dr32 = '0;

  logic rdy16, rdy24, rdy32;
  logic sclk16, sclk24, sclk32;
  logic lr16, lr24, lr32;
  logic sd16, sd24, sd32;
  logic ur16, ur24, ur32;

  int tests = 0;
  int fails = 0;

  always #5 mclk = ~mclk;

  i2s_p2s #(.BIT_NUM(16)) u_dut16 (
    .mclk_i(mclk), .rst_i(rst), .data_l_i(dl16), .data_r_i(dr16), .data_valid_i(valid),
    .data_ready_o(rdy16), .mute_i(mute), .sclk_o(sclk16), .lrclk_o(lr16), .sdata_o(sd16),
    .underrun_o(ur16));

  i2s_p2s #(.BIT_NUM(24)) u_dut24 (
    .mclk_i(mclk), .rst_i(rst), .data_l_i(dl24), .data_r_i(dr24), .data_valid_i(valid),
    .data_ready_o(rdy24), .mute_i(mute), .sclk_o(sclk24), .lrclk_o(lr24), .sdata_o(sd24),
    .underrun_o(ur24));

  i2s_p2s #(.BIT_NUM(32)) u_dut32 (
    .mclk_i(mclk), .rst_i(rst), .data_l_i(dl32), .data_r_i(dr32), .data_valid_i(valid),
    .data_ready_o(rdy32), .mute_i(mute), .sclk_o(sclk32), .lrclk_o(lr32), .sdata_o(sd32),
    .underrun_o(ur32));

  // Sample pairs: 1 = A, 2 = B, 3 = C.
  logic [15:0] l16 [4], r16 [4];
  logic [23:0] l24 [4], r24 [4];
  logic [31:0] l32 [4], r32 [4];
  // Expected frame words: 0 = silence, 1 = pair A.
  logic [63:0] e16 [2], e24 [2], e32 [2];

  typedef struct {
    string       name;
    int          pair;
    bit          oneshot;
    bit          valid_end;
    bit          mute_end;
    int          exp_sel;
    logic [2:0]  exp_p0;
    int          exp_under;
    int          exp_ready;
    int          exp_acc;
  } vec_t;

  vec_t vecs [18];

  logic [63:0] fw16, fw24, fw32;
  logic [2:0]  p0;
  int n_under, n_ready, n_acc, n_err, first_under;

  function automatic vec_t mk(string nm, int pair, bit os, bit ve, bit me, int sel,
                              logic [2:0] p0e, int ur, int rd, int ac);
    vec_t v;
    v.name = nm; v.pair = pair; v.oneshot = os; v.valid_end = ve; v.mute_end = me;
    v.exp_sel = sel; v.exp_p0 = p0e; v.exp_under = ur; v.exp_ready = rd; v.exp_acc = ac;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive_pair(input int p);
    dl16 = l16[p]; dr16 = r16[p];
    dl24 = l24[p]; dr24 = r24[p];
    dl32 = l32[p]; dr32 = r32[p];
  endtask

  // Runs one 256-MCLK frame starting just after a boundary (cnt = 0), decoding on SCLK high.
  task automatic run_frame(input bit oneshot, input bit valid_end, input bit mute_end, input int pair);
    bit         go;
    logic [7:0] c;
    logic [2:0] sdp;
    fw16 = '0; fw24 = '0; fw32 = '0; p0 = '0; sdp = '0;
    n_under = 0; n_ready = 0; n_acc = 0; n_err = 0; first_under = -1;
    for (int i = 0; i < 256; i++) begin
      @(negedge mclk);
      c = 8'(i);
      if (i == 255 && valid_end) begin
        drive_pair(pair);
        valid = 1'b1;
      end
      if (i == 255 && mute_end) mute = 1'b1;
      if (sclk16 !== c[1] || sclk24 !== c[1] || sclk32 !== c[1]) n_err++;
      if (lr16 !== c[7] || lr24 !== c[7] || lr32 !== c[7]) n_err++;
      if (ur24 !== ur16 || ur32 !== ur16 || rdy24 !== rdy16 || rdy32 !== rdy16) n_err++;
      if (c[1:0] == 2'd0) sdp = {sd32, sd24, sd16};
      else if ({sd32, sd24, sd16} !== sdp) n_err++;
      if (ur16 === 1'b1) begin
        n_under++;
        if (first_under < 0) first_under = i;
      end
      if (rdy16 === 1'b1) n_ready++;
      if (c[1:0] == 2'd2) begin
        if (c[7:2] == 6'd0) p0 = {sd32, sd24, sd16};
        else begin
          fw16[64 - int'(c[7:2])] = sd16;
          fw24[64 - int'(c[7:2])] = sd24;
          fw32[64 - int'(c[7:2])] = sd32;
        end
      end
      go = valid && (rdy16 === 1'b1);
      if (go) n_acc++;
      @(posedge mclk);
      #1;
      if (go && oneshot) valid = 1'b0;
      if (i == 255 && mute_end) mute = 1'b0;
    end
  endtask

  task automatic apply_vec(input vec_t v);
    logic [63:0] e;
    if (v.pair != 0 && !v.valid_end) begin
      drive_pair(v.pair);
      valid = 1'b1;
    end else begin
      valid = 1'b0;
    end
    run_frame(v.oneshot, v.valid_end, v.mute_end, v.pair);
    e = e16[v.exp_sel];
    check($sformatf("%s.fw16", v.name), {fw16[63:1], 1'b0}, {e[63:1], 1'b0});
    e = e24[v.exp_sel];
    check($sformatf("%s.fw24", v.name), {fw24[63:1], 1'b0}, {e[63:1], 1'b0});
    e = e32[v.exp_sel];
    check($sformatf("%s.fw32", v.name), {fw32[63:1], 1'b0}, {e[63:1], 1'b0});
    check($sformatf("%s.p0bit", v.name), 64'(p0), 64'(v.exp_p0));
    check($sformatf("%s.underrun", v.name), 64'(n_under), 64'(v.exp_under));
    if (v.exp_under == 1)
      check($sformatf("%s.underrun_pos", v.name), 64'(first_under), 64'd0);
    check($sformatf("%s.ready_cycles", v.name), 64'(n_ready), 64'(v.exp_ready));
    check($sformatf("%s.accepts", v.name), 64'(n_acc), 64'(v.exp_acc));
    check($sformatf("%s.clk_shape", v.name), 64'(n_err), 64'd0);
  endtask

  initial begin
    l16[0] = '0;           r16[0] = '0;
    l24[0] = '0;           r24[0] = '0;
    l32[0] = '0;           r32[0] = '0;
    l16[1] = 16'h8001;     r16[1] = 16'h7FFE;
    l24[1] = 24'h800001;   r24[1] = 24'h7FFFFE;
    l32[1] = 32'h80000001; r32[1] = 32'h7FFFFFFF;
    l16[2] = 16'h1234;     r16[2] = 16'hC3A5;
    l24[2] = 24'h123456;   r24[2] = 24'hC3A55A;
    l32[2] = 32'h12345678; r32[2] = 32'hC3A55A3C;
    l16[3] = 16'hFFFF;     r16[3] = 16'hF000;
    l24[3] = 24'hFFFFFF;   r24[3] = 24'hF00000;
    l32[3] = 32'hFFFFFFFF; r32[3] = 32'hF0000000;
    e16[0] = '0; e24[0] = '0; e32[0] = '0;
    e16[1] = 64'h8001_0000_7FFE_0000;
    e24[1] = 64'h8000_0100_7FFF_FE00;
    e32[1] = 64'h8000_0001_7FFF_FFFF;

    //              name        pair os ve me sel p0      ur  rdy  acc
    vecs[0]  = mk("idle0",      0,   1, 0, 0, 0, 3'b000, 0, 255, 0);
    vecs[1]  = mk("idle1",      0,   1, 0, 0, 0, 3'b000, 1, 256, 0);
    vecs[2]  = mk("load_a",     1,   1, 0, 0, 0, 3'b000, 1, 1,   1);
    vecs[3]  = mk("tx_a",       0,   1, 0, 0, 1, 3'b000, 0, 256, 0);
    vecs[4]  = mk("after_a",    0,   1, 0, 0, 0, 3'b100, 1, 256, 0);
    vecs[5]  = mk("b2b_0",      1,   0, 0, 0, 0, 3'b000, 1, 1,   1);
    vecs[6]  = mk("b2b_1",      1,   0, 0, 0, 1, 3'b000, 0, 1,   1);
    vecs[7]  = mk("b2b_2",      1,   0, 0, 0, 1, 3'b100, 0, 1,   1);
    vecs[8]  = mk("b2b_end",    0,   1, 0, 0, 1, 3'b100, 0, 256, 0);
    vecs[9]  = mk("vb_idle",    1,   1, 1, 0, 0, 3'b100, 1, 256, 1);
    vecs[10] = mk("vb_zero",    0,   1, 0, 0, 0, 3'b000, 1, 0,   0);
    vecs[11] = mk("vb_tx",      0,   1, 0, 0, 1, 3'b000, 0, 256, 0);
    vecs[12] = mk("mute_ld",    2,   1, 0, 1, 0, 3'b100, 1, 1,   1);
    vecs[13] = mk("muted",      1,   1, 0, 0, 0, 3'b000, 0, 1,   1);
    vecs[14] = mk("unmuted",    0,   1, 0, 0, 1, 3'b000, 0, 256, 0);
    vecs[15] = mk("load_c",     3,   1, 0, 0, 0, 3'b100, 1, 1,   1);
    vecs[16] = mk("rst_0",      0,   1, 0, 0, 0, 3'b000, 0, 255, 0);
    vecs[17] = mk("rst_1",      0,   1, 0, 0, 0, 3'b000, 1, 256, 0);

    repeat (3) @(posedge mclk);
    @(negedge mclk);
    check("reset.ready",    64'({rdy32, rdy24, rdy16}),   64'd0);
    check("reset.sclk",     64'({sclk32, sclk24, sclk16}), 64'd0);
    check("reset.lrclk",    64'({lr32, lr24, lr16}),       64'd0);
    check("reset.sdata",    64'({sd32, sd24, sd16}),       64'd0);
    check("reset.underrun", 64'({ur32, ur24, ur16}),       64'd0);
    @(posedge mclk);
    #1;
    rst = 1'b0;

    for (int k = 0; k < 16; k++) apply_vec(vecs[k]);

    // Frame carrying pair C while pair A is held; reset lands at cnt 0x90.
    drive_pair(1);
    valid = 1'b1;
    @(negedge mclk);
    check("mid.ready_at_start", 64'({rdy32, rdy24, rdy16}), 64'h7);
    check("mid.no_underrun",    64'({ur32, ur24, ur16}),    64'd0);
    @(posedge mclk);
    #1;
    valid = 1'b0;
    repeat (8'h8F) @(posedge mclk);
    @(negedge mclk);
    check("mid.lrclk_pre",  64'({lr32, lr24, lr16}),    64'h7);
    check("mid.sdata_pre",  64'({sd32, sd24, sd16}),    64'h7);
    check("mid.held_pre",   64'({rdy32, rdy24, rdy16}), 64'd0);
    rst = 1'b1;
    #1;
    check("mid.sclk_rst",  64'({sclk32, sclk24, sclk16}), 64'd0);
    check("mid.lrclk_rst", 64'({lr32, lr24, lr16}),       64'd0);
    check("mid.sdata_rst", 64'({sd32, sd24, sd16}),       64'd0);
    check("mid.ready_rst", 64'({rdy32, rdy24, rdy16}),    64'd0);
    @(posedge mclk);
    @(posedge mclk);
    #1;
    rst = 1'b0;

    for (int k = 16; k < 18; k++) apply_vec(vecs[k]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2s_p2s.md
# i2s_p2s

I2S master transmitter for the audio DAC path, the output-side counterpart of the ADC deserializer. It runs entirely on MCLK and derives SCLK (MCLK/4) and LRCLK (MCLK/256, 48 kHz at 12.288 MHz). Parallel stereo samples arrive through a valid/ready handshake into a one-deep holding register. At each frame boundary the held samples are serialized MSB-first in Philips I2S format, with 32-bit slots and a one-SCLK data delay.

## Interface
- bitNum, 16: sample width; legal range 8..32; samples are left-justified in each 32-bit slot and zero-padded below.
- MCLK  in  1  master clock (12.288 MHz nominal); the only clock.
- RESET  in  1  asynchronous, active-high reset.
- DATA_L  in  bitNum  left sample, two's complement.
- DATA_R  in  bitNum  right sample, two's complement.
- DATA_VALID  in  1  sample pair valid.
- DATA_READY  out  1  holding register empty; a pair is accepted on an MCLK edge when VALID && READY.
- MUTE  in  1  sampled at the frame boundary; when high, the frame carries zeros.
- SCLK  out  1  bit clock, MCLK/4, 50% duty.
- LRCLK  out  1  word select: 0 = left slot, 1 = right slot.
- SDATA  out  1  serial data; changes only on SCLK falling edges.
- UNDERRUN  out  1  one-MCLK pulse when a frame starts with the holding register empty.

## Operation
- Divider cnt[7:0] free-runs and increments every MCLK; it wraps 0xFF→0x00.
  - SCLK = cnt[1] (registered).
  - LRCLK = cnt[7] (registered).
  - Bit period p = cnt[7:2], range 0..63.
- Frame word F[63:0] = {DATA_L, (32-bitNum)'0, DATA_R, (32-bitNum)'0}.
- Data mapping during period p: SDATA = F[63-(p-1)] for p = 1..63.
  - During p = 0, SDATA = bit 0 of the previous frame (the I2S one-bit delay).
- Holding register: fields hold_l, hold_r, hold_full.
  - DATA_READY = !hold_full, registered.
  - Accept: on VALID && READY, store the pair and set hold_full. This cannot occur when hold_full = 1.
- Frame boundary B is the MCLK edge where cnt goes 0xFF→0x00. At B:
  - If MUTE = 1, the frame register loads 0. Otherwise it loads {hold_l, hold_r} when hold_full = 1, and 0 when hold_full = 0.
  - hold_full clears, so a held pair is consumed even when muted.
  - If hold_full = 0, UNDERRUN pulses high for the cycle following B.
- Accept coincident with B (hold_full = 0): the new pair goes to the holding register, not the frame. The frame is zero and UNDERRUN pulses, and hold_full = 1 after the edge.
- Arithmetic: cnt is modulo-256; no saturation is needed anywhere.

## Timing
- Output register update: SDATA loads at the MCLK edge where cnt[1:0] goes 3→0, coincident with SCLK's falling edge. The DAC samples on SCLK rising (cnt[1:0] 1→2).
- LRCLK toggles at cnt 0x7F→0x80 and 0xFF→0x00, on SCLK falling edges.
- Latency: a pair accepted on or before the edge preceding B has its L MSB on SDATA from the edge cnt 0x03→0x04. The R MSB appears from cnt 0x83→0x84.
- Throughput: one pair per 256 MCLK. DATA_READY reasserts on the edge after B.
- Reset values: cnt = 0, SCLK = 0, LRCLK = 0, SDATA = 0, frame register = 0, hold_full = 0, DATA_READY = 0 while RESET is high and 1 from the first edge after release, UNDERRUN = 0.
- Reset mid-frame: asynchronously forces all of the above values. Any held pair is discarded. After release the first frame starts at cnt = 0 and carries zeros, and the first B (256 cycles later) raises UNDERRUN if nothing has been supplied.

## Structure
- Shared package `i2s_pkg`:
  - SCLK_DIV = 4
  - SLOT_BITS = 32
  - FRAME_BITS = 64
  - LR_DIV = 256
  - Slot-padding helper function
- Sub-module `i2s_clkgen`: divider counter plus registered SCLK, LRCLK, a frame-boundary strobe and a bit-advance strobe. It can be reused by other I2S-master blocks.
- Top level: holding register and handshake, frame shift register, mute and underrun logic.

## Test plan
- Reset release, no input → SCLK period 4 MCLK, LRCLK period 256 MCLK; SDATA = 0 throughout; UNDERRUN pulses once per frame, starting 256 cycles after release.
- bitNum = 16, supply L = 0x8001, R = 0x7FFE before B.
  - Decode on SCLK rising: left slot bits 1..16 = 0x8001, right slot bits 1..16 = 0x7FFE, all padding bits 0.
  - The bit in period 0 of the next frame equals the previous LSB padding (0).
- Back-to-back VALID held high → exactly one accept per frame; DATA_READY low for ~255 cycles then high for 1 cycle after each B; no UNDERRUN.
- VALID asserted exactly on edge B with the holding register empty → that frame is zeros and UNDERRUN pulses. The pair is transmitted in the following frame.
- MUTE = 1 at B with a pair held → frame is zeros, the pair is consumed and DATA_READY = 1 after B. MUTE = 0 at the next B → the next supplied pair is transmitted normally.
- RESET pulsed at cnt = 0x90 with a pair held → SCLK, LRCLK and SDATA go to 0 immediately; after release the held pair is never transmitted; bitNum = 24 and 32 regressions repeat the second scenario.
